// File: rtl/fp_dp_fix_result_buffer.sv
// fp_dp_fix_result_buffer
// Collects results from the fixed-latency double-precision FP-to-fixed
// converter. A valid/tag shift register follows each issued op through the
// converter, the result is captured into a small FIFO when it emerges, and
// the FIFO head is offered to writeback with valid/ready. Issue credit
// (in-flight ops plus buffered results) never exceeds DEPTH, so the FIFO
// cannot overflow.
// Optional feature: define FP_DP_FIX_SAT_FLAG_EN to add a per-result
// saturation flag (out_sat) that travels with the FIFO head.
module fp_dp_fix_result_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 6,
    parameter int LATENCY    = 4,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_valid,
    input  logic [TAG_WIDTH-1:0]         issue_tag,
    output logic                         issue_ready,
    input  logic                         flush,
    input  logic [DATA_WIDTH-1:0]        conv_res,
    output logic                         out_valid,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [TAG_WIDTH-1:0]         out_tag,
`ifdef FP_DP_FIX_SAT_FLAG_EN
    output logic                         out_sat,
`endif
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   inflight_cnt
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    // Tracking pipe: one {valid, tag} per converter stage
    logic [LATENCY-1:0]   pipe_valid_q, pipe_valid_d;
    logic [TAG_WIDTH-1:0] pipe_tag_q [LATENCY];
    logic [TAG_WIDTH-1:0] pipe_tag_d [LATENCY];

    // Occupancy counters and FIFO pointers
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] rd_ptr_inc;

    // FIFO storage and registered head copy (keeps outputs stable and resettable)
    logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
    logic [TAG_WIDTH-1:0]  mem_tag_q  [DEPTH];
    logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
    logic [TAG_WIDTH-1:0]  head_tag_q, head_tag_d;

`ifdef FP_DP_FIX_SAT_FLAG_EN
    localparam logic [DATA_WIDTH-1:0] SAT_POS = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    logic mem_sat_q [DEPTH];
    logic head_sat_q, head_sat_d;
    logic push_sat;
`endif

    logic [CNT_W:0] credit_used;
    logic           accept;
    logic           capture;
    logic           push;
    logic           pop;

    // Handshake and credit decode from registered state only
    always_comb begin
        credit_used = {1'b0, inflight_q} + {1'b0, count_q};
        issue_ready = credit_used < (CNT_W+1)'(DEPTH);
        out_valid   = count_q != '0;
        accept      = issue_valid & issue_ready & ~flush;
        capture     = pipe_valid_q[LATENCY-1];
        push        = capture & ~flush;
        pop         = out_valid & out_ready & ~flush;
        rd_ptr_inc  = rd_ptr_q + PTR_W'(1);
    end

`ifdef FP_DP_FIX_SAT_FLAG_EN
    // Saturation is recognised by the two extreme fixed-point codes
    always_comb begin
        push_sat = (conv_res == SAT_POS) | (conv_res == SAT_NEG);
    end
`endif

    // Tracking pipe shifts every cycle since the converter cannot stall
    always_comb begin
        pipe_valid_d    = '0;
        pipe_tag_d[0]   = issue_tag;
        pipe_valid_d[0] = accept;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_tag_d[i]   = pipe_tag_q[i-1];
        end
        if (flush) begin
            pipe_valid_d = '0;
        end
    end

    // Counters and pointers; flush empties everything in one edge
    always_comb begin
        inflight_d = inflight_q + CNT_W'(accept) - CNT_W'(capture);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_inc : rd_ptr_q;
        if (flush) begin
            inflight_d = '0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    // Next head entry: follows the pop or the push into an empty/draining FIFO
    always_comb begin
        head_data_d = head_data_q;
        head_tag_d  = head_tag_q;
`ifdef FP_DP_FIX_SAT_FLAG_EN
        head_sat_d  = head_sat_q;
`endif
        if (!flush) begin
            if (count_q == '0 && push) begin
                head_data_d = conv_res;
                head_tag_d  = pipe_tag_q[LATENCY-1];
`ifdef FP_DP_FIX_SAT_FLAG_EN
                head_sat_d  = push_sat;
`endif
            end else if (pop && count_q >= CNT_W'(2)) begin
                head_data_d = mem_data_q[rd_ptr_inc];
                head_tag_d  = mem_tag_q[rd_ptr_inc];
`ifdef FP_DP_FIX_SAT_FLAG_EN
                head_sat_d  = mem_sat_q[rd_ptr_inc];
`endif
            end else if (pop && push) begin
                head_data_d = conv_res;
                head_tag_d  = pipe_tag_q[LATENCY-1];
`ifdef FP_DP_FIX_SAT_FLAG_EN
                head_sat_d  = push_sat;
`endif
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag_q[i] <= '0;
            end
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            head_data_q <= '0;
            head_tag_q  <= '0;
`ifdef FP_DP_FIX_SAT_FLAG_EN
            head_sat_q  <= 1'b0;
`endif
        end else begin
            pipe_valid_q <= pipe_valid_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag_q[i] <= pipe_tag_d[i];
            end
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            head_data_q <= head_data_d;
            head_tag_q  <= head_tag_d;
`ifdef FP_DP_FIX_SAT_FLAG_EN
            head_sat_q  <= head_sat_d;
`endif
        end
    end

    // FIFO storage is plain RAM; validity comes from count and pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= conv_res;
            mem_tag_q[wr_ptr_q]  <= pipe_tag_q[LATENCY-1];
`ifdef FP_DP_FIX_SAT_FLAG_EN
            mem_sat_q[wr_ptr_q]  <= push_sat;
`endif
        end
    end

    assign out_data     = head_data_q;
    assign out_tag      = head_tag_q;
    assign inflight_cnt = inflight_q;
`ifdef FP_DP_FIX_SAT_FLAG_EN
    assign out_sat      = head_sat_q;
`endif

    // The credit rule makes a push into a full FIFO impossible
    overflow_check: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && count_q == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fp_dp_fix_result_buffer.sv
// Testbench for fp_dp_fix_result_buffer (LATENCY=4, DEPTH=4).
// Directed vectors; expected values hand-derived from the credit rule
// inflight+count < DEPTH and the LATENCY+1 issue-to-output delay.
module tb_fp_dp_fix_result_buffer;

    localparam logic [63:0] RAMP = 64'hC0DE_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        issue_valid;
    logic [5:0]  issue_tag;
    logic        issue_ready;
    logic        flush;
    logic [63:0] conv_res;
    logic        out_valid;
    logic [63:0] out_data;
    logic [5:0]  out_tag;
`ifdef FP_DP_FIX_SAT_FLAG_EN
    logic        out_sat;
`endif
    logic        out_ready;
    logic [2:0]  inflight_cnt;

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;
    bit rampOn     = 1'b0;

    fp_dp_fix_result_buffer #(
        .DATA_WIDTH(64), .TAG_WIDTH(6), .LATENCY(4), .DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_tag(issue_tag), .issue_ready(issue_ready),
        .flush(flush), .conv_res(conv_res),
        .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag),
`ifdef FP_DP_FIX_SAT_FLAG_EN
        .out_sat(out_sat),
`endif
        .out_ready(out_ready), .inflight_cnt(inflight_cnt)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [5:0] tg, input logic ordy, input logic fl);
        issue_valid = iv;
        issue_tag   = tg;
        out_ready   = ordy;
        flush       = fl;
    endtask

    // Advance one cycle; inputs and checks happen 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rampOn) conv_res = RAMP + 64'(cyc);
    endtask

    task automatic startRamp();
        cyc      = 0;
        rampOn   = 1'b1;
        conv_res = RAMP;
    endtask

    bit expReady [15] = '{1,1,1,1,0,0,1,1,1,1,0,0,1,1,1};
    bit expValid [15] = '{0,0,0,0,0,1,1,1,1,0,0,1,1,1,1};

    initial begin
        int nextTag;
        int outIdx;
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
        conv_res = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_tag", out_tag, 0);
        checkOutput("rst_inflight", inflight_cnt, 0);
        checkOutput("rst_ready", issue_ready, 1);
        rst = 1'b1;
        tick();

        // Single op: visible 5 cycles after accept
        $display("[TB] single op");
        cyc = 0; rampOn = 1'b0; conv_res = '0;
        applyStimulus(1'b1, 6'h05, 1'b0, 1'b0);
        checkOutput("t1_ready", issue_ready, 1);
        tick();
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            checkOutput("t1_inflight", inflight_cnt, 1);
            checkOutput("t1_valid_lo", out_valid, 0);
            if (c == 4) conv_res = 64'h2A;
            tick();
        end
        conv_res = '0;
        checkOutput("t1_inflight_done", inflight_cnt, 0);
        checkOutput("t1_valid", out_valid, 1);
        checkOutput("t1_data", out_data, 64'h2A);
        checkOutput("t1_tag", out_tag, 6'h05);
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
        tick();
        checkOutput("t1_drained", out_valid, 0);

        // Back-pressure: credit limits issue to DEPTH ops
        $display("[TB] back-pressure");
        startRamp();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 6'(i), 1'b0, 1'b0);
            checkOutput("t2_ready", issue_ready, (i < 4) ? 1 : 0);
            tick();
        end
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
        repeat (3) tick();
        checkOutput("t2_full_valid", out_valid, 1);
        checkOutput("t2_full_inflight", inflight_cnt, 0);
        checkOutput("t2_full_ready", issue_ready, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
            checkOutput("t2_out_valid", out_valid, 1);
            checkOutput("t2_out_tag", out_tag, 64'(i));
            checkOutput("t2_out_data", out_data, RAMP + 64'(4 + i));
            tick();
        end
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
        checkOutput("t2_empty", out_valid, 0);
        checkOutput("t2_ready_back", issue_ready, 1);

        // Continuous issue with out_ready=1: credit throttles in bursts
        $display("[TB] streaming");
        startRamp();
        nextTag = 0;
        outIdx  = 0;
        for (int c = 0; c < 15; c++) begin
            applyStimulus(1'b1, 6'(8'h10 + nextTag), 1'b1, 1'b0);
            checkOutput("t3_ready", issue_ready, 64'(expReady[c]));
            checkOutput("t3_valid", out_valid, 64'(expValid[c]));
            if (expValid[c]) begin
                checkOutput("t3_tag", out_tag, 64'(8'h10 + outIdx));
                checkOutput("t3_data", out_data, RAMP + 64'(c - 1));
                outIdx++;
            end
            if (expReady[c]) nextTag++;
            tick();
        end
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
        repeat (10) tick();
        checkOutput("t3_drain_valid", out_valid, 0);
        checkOutput("t3_drain_inflight", inflight_cnt, 0);

        // Flush with 2 in flight, 2 buffered, and an issue in the flush cycle
        $display("[TB] flush");
        startRamp();
        applyStimulus(1'b1, 6'h20, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 6'h21, 1'b0, 1'b0); tick();
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0); tick();
        tick();
        applyStimulus(1'b1, 6'h22, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 6'h23, 1'b0, 1'b0); tick();
        checkOutput("t4_pre_valid", out_valid, 1);
        checkOutput("t4_pre_tag", out_tag, 6'h20);
        checkOutput("t4_pre_inflight", inflight_cnt, 2);
        checkOutput("t4_pre_ready", issue_ready, 0);
        applyStimulus(1'b1, 6'h24, 1'b0, 1'b1); tick();
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
        checkOutput("t4_valid", out_valid, 0);
        checkOutput("t4_inflight", inflight_cnt, 0);
        checkOutput("t4_ready", issue_ready, 1);
        for (int c = 0; c < 8; c++) begin
            tick();
            checkOutput("t4_no_output", out_valid, 0);
        end

        // Asynchronous reset between edges with 3 ops in flight
        $display("[TB] async reset");
        startRamp();
        applyStimulus(1'b1, 6'h30, 1'b0, 1'b0); tick();
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 6'h31, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 6'h32, 1'b0, 1'b0); tick();
        applyStimulus(1'b1, 6'h33, 1'b0, 1'b0); tick();
        applyStimulus(1'b0, 6'h00, 1'b0, 1'b0);
        checkOutput("t5_pre_valid", out_valid, 1);
        checkOutput("t5_pre_inflight", inflight_cnt, 3);
        #2 rst = 1'b0;
        #1;
        checkOutput("t5_valid", out_valid, 0);
        checkOutput("t5_data", out_data, 0);
        checkOutput("t5_tag", out_tag, 0);
        checkOutput("t5_inflight", inflight_cnt, 0);
        checkOutput("t5_ready", issue_ready, 1);
        #2 rst = 1'b1;
        applyStimulus(1'b0, 6'h00, 1'b1, 1'b0);
        for (int c = 0; c < 8; c++) begin
            tick();
            checkOutput("t5_no_stale", out_valid, 0);
            checkOutput("t5_no_inflight", inflight_cnt, 0);
        end

`ifdef FP_DP_FIX_SAT_FLAG_EN
        // Saturation flag follows each result to the head
        $display("[TB] saturation flag");
        rampOn = 1'b0; cyc = 0; conv_res = '0;
        for (int c = 0; c < 10; c++) begin
            applyStimulus(c < 3, 6'(c + 1), c >= 7, 1'b0);
            case (c)
                4: conv_res = 64'h7FFF_FFFF_FFFF_FFFF;
                5: conv_res = 64'h8000_0000_0000_0000;
                6: conv_res = 64'h0000_0000_0000_0010;
                default: conv_res = 64'h0;
            endcase
            if (c == 7) checkOutput("sat_pos", out_sat, 1);
            if (c == 8) checkOutput("sat_neg", out_sat, 1);
            if (c == 9) checkOutput("sat_none", out_sat, 0);
            tick();
        end
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
